// File: rtl/cmp_pkg.sv
// Shared definitions for the sequential min/max tracker: default widths and
// the FSM state encoding used by cmp_minmax_seq.
package cmp_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int CNT_W_DEF  = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ACCEPT  = 3'd1,
    ST_CMP_MAX = 3'd2,
    ST_CMP_MIN = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

endpackage : cmp_pkg

// File: rtl/mag_cmp.sv
// Unsigned W-bit magnitude comparator with one-hot greater/equal/less outputs.
module mag_cmp #(
  parameter int W = 8
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic         agtb_o,
  output logic         aeqb_o,
  output logic         altb_o
);

  // Pure combinational compare; exactly one output is high for known inputs.
  always_comb begin
    agtb_o = (a_i > b_i);
    aeqb_o = (a_i == b_i);
    altb_o = (a_i < b_i);
  end

endmodule : mag_cmp

// File: rtl/cmp_minmax_seq.sv
// Sequential min/max tracker. Samples arrive over a valid/ready handshake;
// one shared magnitude comparator is used first against the running maximum
// and then against the running minimum. Max, min and a saturating sample
// count are reported at end of frame with a one-cycle done pulse.
//
// Optional build macro MINMAX_INDEX_EN adds max_idx/min_idx outputs holding
// the 0-based position of the first sample that holds the frame max/min.
module cmp_minmax_seq
  import cmp_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  input  logic              din_last,
  output logic [DATA_W-1:0] max_out,
  output logic [DATA_W-1:0] min_out,
  output logic [CNT_W-1:0]  count,
  output logic              busy,
  output logic              done
`ifdef MINMAX_INDEX_EN
  ,
  output logic [CNT_W-1:0]  max_idx,
  output logic [CNT_W-1:0]  min_idx
`endif
);

  state_e state_q, state_d;

  logic [DATA_W-1:0] max_q, max_d;
  logic [DATA_W-1:0] min_q, min_d;
  logic [DATA_W-1:0] s_q, s_d;
  logic              last_q, last_d;
  logic              first_q, first_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  cnt_inc;
  logic              ready_q, busy_q, done_q;

`ifdef MINMAX_INDEX_EN
  logic [CNT_W-1:0]  s_idx_q, s_idx_d;
  logic [CNT_W-1:0]  max_idx_q, max_idx_d;
  logic [CNT_W-1:0]  min_idx_q, min_idx_d;
`endif

  logic [DATA_W-1:0] cmp_b;
  logic              agtb, aeqb, altb;
  logic              upd_max, upd_min;

  // Comparator B operand: running minimum during CMP_MIN, running maximum otherwise.
  assign cmp_b = (state_q == ST_CMP_MIN) ? min_q : max_q;

  mag_cmp #(.W(DATA_W)) u_mag_cmp (
    .a_i    (s_q),
    .b_i    (cmp_b),
    .agtb_o (agtb),
    .aeqb_o (aeqb),
    .altb_o (altb)
  );

  // An equal sample explicitly holds the tracked value, so the first
  // occurrence of an extreme keeps its index.
  assign upd_max = agtb & ~aeqb;
  assign upd_min = altb & ~aeqb;

  // Saturating increment: the count sticks at all-ones instead of wrapping.
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

  // Next-state and datapath decode for the frame FSM.
  always_comb begin
    // NOTE: every variable gets a default here so no path leaves it unassigned; otherwise a latch is inferred.
    state_d = state_q;
    max_d   = max_q;
    min_d   = min_q;
    s_d     = s_q;
    last_d  = last_q;
    first_d = first_q;
    cnt_d   = cnt_q;
`ifdef MINMAX_INDEX_EN
    s_idx_d   = s_idx_q;
    max_idx_d = max_idx_q;
    min_idx_d = min_idx_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          cnt_d   = '0;
          first_d = 1'b1;
          state_d = ST_ACCEPT;
        end
      end

      ST_ACCEPT: begin
        if (din_valid) begin
          s_d    = din;
          last_d = din_last;
          cnt_d  = cnt_inc;
`ifdef MINMAX_INDEX_EN
          s_idx_d = cnt_inc - CNT_W'(1);
`endif
          if (first_q) begin
            first_d = 1'b0;
            max_d   = din;
            min_d   = din;
`ifdef MINMAX_INDEX_EN
            max_idx_d = '0;
            min_idx_d = '0;
`endif
            state_d = din_last ? ST_DONE : ST_ACCEPT;
          end else begin
            state_d = ST_CMP_MAX;
          end
        end
      end

      ST_CMP_MAX: begin
        if (upd_max) begin
          max_d = s_q;
`ifdef MINMAX_INDEX_EN
          max_idx_d = s_idx_q;
`endif
        end
        state_d = ST_CMP_MIN;
      end

      ST_CMP_MIN: begin
        if (upd_min) begin
          min_d = s_q;
`ifdef MINMAX_INDEX_EN
          min_idx_d = s_idx_q;
`endif
        end
        state_d = last_q ? ST_DONE : ST_ACCEPT;
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; handshake/status outputs are decoded from the
  // next state so they come straight out of flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      max_q   <= '0;
      min_q   <= '0;
      s_q     <= '0;
      last_q  <= 1'b0;
      first_q <= 1'b0;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef MINMAX_INDEX_EN
      s_idx_q   <= '0;
      max_idx_q <= '0;
      min_idx_q <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
      state_q <= state_d;
      max_q   <= max_d;
      min_q   <= min_d;
      s_q     <= s_d;
      last_q  <= last_d;
      first_q <= first_d;
      cnt_q   <= cnt_d;
      ready_q <= (state_d == ST_ACCEPT);
      busy_q  <= (state_d != ST_IDLE);
      done_q  <= (state_d == ST_DONE);
`ifdef MINMAX_INDEX_EN
      s_idx_q   <= s_idx_d;
      max_idx_q <= max_idx_d;
      min_idx_q <= min_idx_d;
`endif
    end
  end

  assign din_ready = ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign max_out   = max_q;
  assign min_out   = min_q;
  assign count     = cnt_q;
`ifdef MINMAX_INDEX_EN
  assign max_idx   = max_idx_q;
  assign min_idx   = min_idx_q;
`endif

endmodule : cmp_minmax_seq

// File: tb/tb_cmp_minmax_seq.sv
// Bench for cmp_minmax_seq: two instances (CNT_W=8 and CNT_W=2) share all
// inputs. A frame-level reference model predicts every output each cycle;
// directed frames add literal expectations for latency and final values.
module tb_cmp_minmax_seq;

  logic       clk = 1'b0;
  logic       rst, start, din_valid, din_last;
  logic [7:0] din;

  logic       rdy8, busy8, done8;
  logic [7:0] max8, min8, cnt8;
  logic       rdy2, busy2, done2;
  logic [7:0] max2, min2;
  logic [1:0] cnt2;
`ifdef MINMAX_INDEX_EN
  logic [7:0] maxi8, mini8;
  logic [1:0] maxi2, mini2;
`endif

  always #5 clk = ~clk;

  cmp_minmax_seq #(.DATA_W(8), .CNT_W(8)) dut8 (
    .clk(clk), .rst(rst), .start(start), .din(din), .din_valid(din_valid),
    .din_ready(rdy8), .din_last(din_last), .max_out(max8), .min_out(min8),
    .count(cnt8), .busy(busy8), .done(done8)
`ifdef MINMAX_INDEX_EN
    , .max_idx(maxi8), .min_idx(mini8)
`endif
  );

  cmp_minmax_seq #(.DATA_W(8), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .start(start), .din(din), .din_valid(din_valid),
    .din_ready(rdy2), .din_last(din_last), .max_out(max2), .min_out(min2),
    .count(cnt2), .busy(busy2), .done(done2)
`ifdef MINMAX_INDEX_EN
    , .max_idx(maxi2), .min_idx(mini2)
`endif
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model (frame-level rules) ----------------
  bit         m_busy, m_ready, m_done, m_first, m_last, chk_en;
  int         m_pend;
  logic [7:0] m_max, m_min, m_s;
  int         m_cnt8, m_cnt2, m_sidx, m_maxidx, m_minidx;

  task automatic step_model();
    if (rst) begin
      m_busy = 0; m_ready = 0; m_done = 0; m_first = 0; m_last = 0; m_pend = 0;
      m_max = 0; m_min = 0; m_s = 0; m_cnt8 = 0; m_cnt2 = 0;
      m_sidx = 0; m_maxidx = 0; m_minidx = 0;
      chk_en = 1;
    end else if (m_done) begin
      m_done = 0;
      m_busy = 0;
    end else if (!m_busy) begin
      if (start) begin
        m_busy = 1; m_ready = 1; m_first = 1; m_cnt8 = 0; m_cnt2 = 0;
      end
    end else if (m_ready) begin
      if (din_valid) begin
        m_cnt8 = (m_cnt8 < 255) ? m_cnt8 + 1 : 255;
        m_cnt2 = (m_cnt2 < 3) ? m_cnt2 + 1 : 3;
        m_sidx = m_cnt8 - 1;
        m_ready = 0;
        if (m_first) begin
          m_first = 0;
          m_max = din; m_min = din; m_maxidx = 0; m_minidx = 0;
          if (din_last) m_done = 1;
          else m_ready = 1;
        end else begin
          m_s = din; m_last = din_last; m_pend = 2;
        end
      end
    end else if (m_pend == 2) begin
      if (m_s > m_max) begin m_max = m_s; m_maxidx = m_sidx; end
      m_pend = 1;
    end else if (m_pend == 1) begin
      if (m_s < m_min) begin m_min = m_s; m_minidx = m_sidx; end
      m_pend = 0;
      if (m_last) m_done = 1;
      else m_ready = 1;
    end
  endtask

  initial begin
    chk_en = 0;
    forever begin
      @(posedge clk);
      step_model();
    end
  end

  // Per-cycle comparison of both instances against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("ready8", 32'(rdy8), 32'(m_ready));
        check("busy8", 32'(busy8), 32'(m_busy));
        check("done8", 32'(done8), 32'(m_done));
        check("max8", 32'(max8), 32'(m_max));
        check("min8", 32'(min8), 32'(m_min));
        check("count8", 32'(cnt8), 32'(m_cnt8));
        check("ready2", 32'(rdy2), 32'(m_ready));
        check("done2", 32'(done2), 32'(m_done));
        check("max2", 32'(max2), 32'(m_max));
        check("min2", 32'(min2), 32'(m_min));
        check("count2", 32'(cnt2), 32'(m_cnt2));
`ifdef MINMAX_INDEX_EN
        check("max_idx8", 32'(maxi8), 32'(m_maxidx));
        check("min_idx8", 32'(mini8), 32'(m_minidx));
`endif
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  logic [7:0] fr_q[$];
  bit         rand_mode;

  // Present one sample and hold it until a transfer; t = accept cycle.
  task automatic push(input logic [7:0] v, input logic l, output int t);
    logic r;
    int   guard;
    din = v; din_last = l; din_valid = 1'b1;
    guard = 0;
    t = -1;
    forever begin
      @(negedge clk);
      r = rdy8;
      @(posedge clk);
      #2;
      if (r) begin
        t = cyc - 1;
        break;
      end
      guard++;
      if (guard > 20) begin
        check("ready_timeout", 32'(r), 32'd1);
        break;
      end
    end
  endtask

  // Pulse start from IDLE, then deliver fr_q; t_last = accept cycle of last sample.
  task automatic run_frame(output int t_last);
    int t;
    start = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
    t = -1;
    for (int i = 0; i < fr_q.size(); i++) begin
      if (rand_mode) begin
        repeat ($urandom_range(0, 2)) begin
          din_valid = 1'b0;
          din = 8'($urandom);
          start = 1'($urandom);
          @(posedge clk);
          #2;
        end
        start = (i != fr_q.size() - 1) ? 1'($urandom) : 1'b0;
      end
      push(fr_q[i], (i == fr_q.size() - 1), t);
      start = 1'b0;
    end
    din_valid = 1'b0;
    din_last = 1'b0;
    t_last = t;
  endtask

  // Wait (bounded) for the done pulse; returns in the following IDLE cycle.
  task automatic wait_done(output int t);
    t = -1;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (done8 === 1'b1) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) check("done_seen", 32'd0, 32'd1);
    @(posedge clk);
    #2;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int tl, td;
    rst = 1'b1; start = 1'b0; din_valid = 1'b0; din_last = 1'b0; din = '0;
    rand_mode = 0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;

    @(negedge clk);
    check("rst_max", 32'(max8), 32'h0);
    check("rst_min", 32'(min8), 32'h0);
    check("rst_count", 32'(cnt8), 32'h0);
    check("rst_busy", 32'(busy8), 32'h0);
    check("rst_ready", 32'(rdy8), 32'h0);
    @(posedge clk);
    #2;

    // Basic frame with a repeated maximum.
    fr_q = '{8'h10, 8'h80, 8'h05, 8'h80};
    run_frame(tl);
    wait_done(td);
    check("f1_latency", 32'(td - tl), 32'd3);
    check("f1_max", 32'(max8), 32'h80);
    check("f1_min", 32'(min8), 32'h05);
    check("f1_count", 32'(cnt8), 32'd4);
`ifdef MINMAX_INDEX_EN
    check("f1_max_idx", 32'(maxi8), 32'd1);
    check("f1_min_idx", 32'(mini8), 32'd2);
`endif
    @(negedge clk);
    check("f1_done_pulse_one", 32'(done8), 32'd0);
    @(posedge clk);
    #2;

    // Single-sample frame.
    fr_q = '{8'h3C};
    run_frame(tl);
    wait_done(td);
    check("f2_latency", 32'(td - tl), 32'd1);
    check("f2_max", 32'(max8), 32'h3C);
    check("f2_min", 32'(min8), 32'h3C);
    check("f2_count", 32'(cnt8), 32'd1);

    // Boundary values.
    fr_q = '{8'h00, 8'hFF, 8'h00, 8'hFF};
    run_frame(tl);
    wait_done(td);
    check("f3_max", 32'(max8), 32'hFF);
    check("f3_min", 32'(min8), 32'h00);
    check("f3_latency", 32'(td - tl), 32'd3);

    // din_valid while idle is ignored.
    din_valid = 1'b1; din = 8'h77;
    repeat (4) @(posedge clk);
    #2;
    din_valid = 1'b0;
    check("idle_count", 32'(cnt8), 32'd4);
    check("idle_busy", 32'(busy8), 32'd0);
    check("idle_max", 32'(max8), 32'hFF);

    // Reset during CMP_MIN of a 3-sample frame.
    start = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
    push(8'h40, 1'b0, tl);
    push(8'h20, 1'b0, tl);
    din_valid = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_busy", 32'(busy8), 32'd0);
    check("mid_rst_max", 32'(max8), 32'd0);
    check("mid_rst_min", 32'(min8), 32'd0);
    check("mid_rst_count", 32'(cnt8), 32'd0);
    check("mid_rst_done", 32'(done8), 32'd0);
    repeat (4) @(posedge clk);
    #2;
    fr_q = '{8'h33, 8'h11};
    run_frame(tl);
    wait_done(td);
    check("after_rst_max", 32'(max8), 32'h33);
    check("after_rst_min", 32'(min8), 32'h11);
    check("after_rst_count", 32'(cnt8), 32'd2);

    // Counter saturation in the narrow instance.
    fr_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    run_frame(tl);
    wait_done(td);
    check("sat_count2", 32'(cnt2), 32'd3);
    check("sat_count8", 32'(cnt8), 32'd5);
    check("sat_max2", 32'(max2), 32'h05);
    check("sat_min2", 32'(min2), 32'h01);

    // Randomized frames with gaps, stray start pulses and frequent ties.
    rand_mode = 1;
    for (int f = 0; f < 40; f++) begin
      int n;
      bit narrow;
      n = $urandom_range(1, 8);
      narrow = 1'($urandom);
      fr_q.delete();
      for (int i = 0; i < n; i++)
        fr_q.push_back(narrow ? 8'($urandom_range(8'h40, 8'h43)) : 8'($urandom));
      run_frame(tl);
      wait_done(td);
      check("rand_latency", 32'(td - tl), (n == 1) ? 32'd1 : 32'd3);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #2;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule : tb_cmp_minmax_seq
